// File: rtl/rs_pkg.sv
// Shared constants and GF(2^8) helpers for the RS(255,239) encoder.
// The generator coefficients are derived at elaboration from the field
// definition. Nothing here ends up in the clocked path as a table; the
// constant multipliers turn each coefficient into a fixed XOR network.
package rs_pkg;

  localparam int          FIELD_W   = 8;
  localparam logic [8:0]  PRIM_POLY = 9'h11D;  // x^8+x^4+x^3+x^2+1
  localparam int          N         = 255;
  localparam int          K         = 239;
  localparam int          NPAR      = N - K;    // 16 check symbols

  // Multiply by alpha (= x) modulo the primitive polynomial.
  function automatic logic [FIELD_W-1:0] gf_xtime(input logic [FIELD_W-1:0] a);
    return {a[FIELD_W-2:0], 1'b0} ^ (a[FIELD_W-1] ? PRIM_POLY[FIELD_W-1:0] : '0);
  endfunction

  // General multiply, used only while computing constants.
  function automatic logic [FIELD_W-1:0] gf_mul(input logic [FIELD_W-1:0] a,
                                                input logic [FIELD_W-1:0] b);
    logic [FIELD_W-1:0] r;
    r = '0;
    for (int i = FIELD_W - 1; i >= 0; i--) begin
      r = gf_xtime(r) ^ (b[i] ? a : '0);
    end
    return r;
  endfunction

  // g(x) = prod_{i=0..15} (x + alpha^i); the monic x^16 term is implicit.
  function automatic logic [NPAR-1:0][FIELD_W-1:0] gen_coeffs();
    logic [NPAR:0][FIELD_W-1:0] g;
    logic [FIELD_W-1:0]         root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int k = NPAR; k > 0; k--) begin
        g[k] = g[k-1] ^ gf_mul(g[k], root);
      end
      g[0] = gf_mul(g[0], root);
      root = gf_xtime(root);
    end
    return g[NPAR-1:0];
  endfunction

  localparam logic [NPAR-1:0][FIELD_W-1:0] G = gen_coeffs();

endpackage

// File: rtl/gf_mul_const.sv
// Constant GF(2^8) multiplier: dout = C * din.
// Ports: din (8-bit operand), dout (8-bit product).
// Product = XOR of C*alpha^j over the set bits j of din; with C fixed,
// each output bit reduces to an XOR of a fixed subset of din bits.
module gf_mul_const
  import rs_pkg::*;
#(
  parameter logic [FIELD_W-1:0] C = 8'h01
) (
  input  logic [FIELD_W-1:0] din,
  output logic [FIELD_W-1:0] dout
);

  function automatic logic [FIELD_W-1:0][FIELD_W-1:0] build_cols(input logic [FIELD_W-1:0] c);
    logic [FIELD_W-1:0][FIELD_W-1:0] cols;
    logic [FIELD_W-1:0]              v;
    v = c;
    for (int j = 0; j < FIELD_W; j++) begin
      cols[j] = v;
      v       = gf_xtime(v);
    end
    return cols;
  endfunction

  localparam logic [FIELD_W-1:0][FIELD_W-1:0] COLS = build_cols(C);

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    dout = '0;
    for (int j = 0; j < FIELD_W; j++) begin
      dout = dout ^ (din[j] ? COLS[j] : '0);
    end
  end

endmodule

// File: rtl/rs_enc_255_239.sv
// Systematic RS(255,239) encoder, one symbol per clock.
// Ports: clk, clrn (async active-low reset), enc_ena (clock enable),
//        data_present (high for the 239 message cycles), message (input
//        symbol), encoded (combinational codeword symbol output).
// Message bytes pass straight through while a 16-stage LFSR divides by
// g(x); with data_present low the remainder shifts out, high stage first.
module rs_enc_255_239
  import rs_pkg::*;
(
  input  logic               clk,
  input  logic               clrn,
  input  logic               enc_ena,
  input  logic               data_present,
  input  logic [FIELD_W-1:0] message,
  output logic [FIELD_W-1:0] encoded
);

  logic [NPAR-1:0][FIELD_W-1:0] p_q, p_d;
  logic [NPAR-1:0][FIELD_W-1:0] prod;
  logic [FIELD_W-1:0]           fb;

  // Forcing the feedback to zero during check cycles turns the divide
  // step into a plain shift with zero fill, so one datapath serves both.
  assign fb = data_present ? (message ^ p_q[NPAR-1]) : '0;

  for (genvar i = 0; i < NPAR; i++) begin : g_mul
    gf_mul_const #(.C(G[i])) u_mul (
      .din  (fb),
      .dout (prod[i])
    );
  end

  always_comb begin
    p_d = p_q;
    if (enc_ena) begin
      p_d[0] = prod[0];
      for (int i = 1; i < NPAR; i++) begin
        p_d[i] = p_q[i-1] ^ prod[i];
      end
    end
  end

  // NOTE: state updates in clocked blocks use non-blocking assignments so
  // every stage samples the previous-cycle value of its neighbour.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign encoded = data_present ? message : p_q[NPAR-1];

endmodule

// File: tb/tb_rs_enc_255_239.sv
module tb_rs_enc_255_239;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       enc_ena = 1'b0;
  logic       data_present = 1'b0;
  logic [7:0] message = 8'h00;
  logic [7:0] encoded;

  int n_checks = 0;
  int n_errors = 0;

  rs_enc_255_239 rs_enc (
    .clk          (clk),
    .clrn         (clrn),
    .enc_ena      (enc_ena),
    .data_present (data_present),
    .message      (message),
    .encoded      (encoded)
  );

  always #5 clk = ~clk;

  // ---------------- reference field arithmetic (log/antilog) ----------------
  logic [7:0] exp_t [256];
  int         log_t [256];
  logic [7:0] gref  [17];   // gref[16] = 1 (monic)

  logic [7:0] msg_a [239];
  logic [7:0] out_a [255];
  logic [7:0] ref_a [255];

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  task automatic build_field();
    logic [8:0] x;
    x = 9'h001;
    for (int i = 0; i < 255; i++) begin
      exp_t[i]      = x[7:0];
      log_t[x[7:0]] = i;
      x = x << 1;
      if (x[8]) x = x ^ 9'h11D;
    end
    exp_t[255] = exp_t[0];
    for (int k = 0; k < 17; k++) gref[k] = 8'h00;
    gref[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int k = 16; k > 0; k--) gref[k] = gref[k-1] ^ mul(gref[k], exp_t[i]);
      gref[0] = mul(gref[0], exp_t[i]);
    end
  endtask

  // Codeword from polynomial long division of m(x)*x^16 by g(x).
  task automatic build_ref();
    logic [7:0] d [255];   // d[deg]
    logic [7:0] q;
    for (int t = 0; t < 239; t++) d[254 - t] = msg_a[t];
    for (int t = 0; t < 16; t++) d[t] = 8'h00;
    for (int deg = 254; deg >= 16; deg--) begin
      q = d[deg];
      for (int j = 0; j <= 16; j++) d[deg - 16 + j] = d[deg - 16 + j] ^ mul(q, gref[j]);
    end
    for (int t = 0; t < 239; t++) ref_a[t] = msg_a[t];
    for (int j = 0; j < 16; j++) ref_a[239 + j] = d[15 - j];
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // One 255-cycle frame; optional 5-cycle stall before cycle stall_at and
  // optional reset pulse (frame abandoned) at cycle rst_at. Starts and ends
  // 1 time unit after a rising edge.
  task automatic run_frame(input int stall_at, input int rst_at);
    for (int t = 0; t < 255; t++) begin
      if (t == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          enc_ena      = 1'b0;
          data_present = 1'b1;
          message      = 8'($urandom);
          @(negedge clk);
          check("stall_passthru", encoded, message);
          @(posedge clk); #1;
        end
      end
      if (t == rst_at) begin
        enc_ena      = 1'b0;
        data_present = 1'b0;
        #2 clrn = 1'b0;
        #1 check("async_clear", encoded, 8'h00);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk); #1;
        return;
      end
      enc_ena      = 1'b1;
      data_present = (t < 239);
      message      = (t < 239) ? msg_a[t] : 8'($urandom);
      @(negedge clk);
      out_a[t] = encoded;
      @(posedge clk); #1;
    end
    enc_ena      = 1'b0;
    data_present = 1'b0;
  endtask

  task automatic compare_frame(input string name);
    build_ref();
    for (int t = 0; t < 255; t++) check(name, out_a[t], ref_a[t]);
  endtask

  task automatic check_syndromes();
    logic [7:0] s;
    for (int i = 0; i < 16; i++) begin
      s = 8'h00;
      for (int t = 0; t < 255; t++) s = mul(s, exp_t[i]) ^ out_a[t];
      check("syndrome", s, 8'h00);
    end
  endtask

  task automatic fill_random();
    for (int t = 0; t < 239; t++) msg_a[t] = 8'($urandom);
  endtask

  typedef struct {
    logic       dp;
    logic [7:0] msg;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    build_field();

    // Combinational output mux with cleared state, enc_ena low.
    vecs[0] = '{1'b1, 8'hA5, 8'hA5};
    vecs[1] = '{1'b0, 8'hA5, 8'h00};
    vecs[2] = '{1'b1, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 8'hFF, 8'hFF};
    vecs[4] = '{1'b0, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 8'h3C, 8'h3C};

    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    @(posedge clk); #1;
    for (int v = 0; v < 6; v++) begin
      data_present = vecs[v].dp;
      message      = vecs[v].msg;
      @(negedge clk);
      check("reset_mux", encoded, vecs[v].exp);
      @(posedge clk); #1;
    end

    // Generator constant sanity: g0 must be alpha^120.
    check("g0_alpha120", gref[0], exp_t[120]);

    // All-zero message.
    for (int t = 0; t < 239; t++) msg_a[t] = 8'h00;
    run_frame(-1, -1);
    for (int t = 0; t < 255; t++) check("zero_frame", out_a[t], 8'h00);

    // Impulse at the last data cycle: parity is g15..g0.
    msg_a[238] = 8'h01;
    run_frame(-1, -1);
    for (int j = 0; j < 16; j++) check("impulse_g", out_a[239 + j], gref[15 - j]);
    check("impulse_last", out_a[254], exp_t[120]);

    // Random frame: reference codeword plus zero syndromes.
    fill_random();
    run_frame(-1, -1);
    compare_frame("random_frame");
    check_syndromes();

    // Two back-to-back frames, no idle cycle in between.
    fill_random();
    run_frame(-1, -1);
    compare_frame("b2b_first");
    fill_random();
    run_frame(-1, -1);
    compare_frame("b2b_second");
    check_syndromes();

    // Enable dropped for 5 cycles mid-message.
    fill_random();
    run_frame(50, -1);
    compare_frame("stall_frame");

    // Reset at cycle 100, then a fresh frame.
    fill_random();
    run_frame(-1, 100);
    fill_random();
    run_frame(-1, -1);
    compare_frame("after_reset");
    check_syndromes();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
